// File: rtl/pattern_bist_pkg.sv
// Shared types and default polynomials for the pattern BIST sequencer.
package pattern_bist_pkg;

    localparam int unsigned LFSR_W = 11;
    localparam int unsigned MISR_W = 10;
    localparam int unsigned PCNT_W = 16;

    // x^11 + x^9 + 1 feeds back lfsr[10]^lfsr[8]; x^10 + x^7 + 1 feeds back misr[9]^misr[6]
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 11'h500;
    localparam logic [MISR_W-1:0] MISR_TAPS    = 10'h240;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 11'h001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_APPLY,
        ST_CAPTURE,
        ST_ADVANCE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bist_shift_reg.sv
// Fibonacci-style shift register: shifts left, feedback into bit 0, optional parallel XOR
// input so the same block serves as LFSR (xin tied 0) or MISR (xin = response).
module bist_shift_reg #(
    parameter int unsigned   W       = 11,
    parameter logic [W-1:0]  TAPS    = '0,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] xin,
    output logic [W-1:0] q
);

    logic [W-1:0] nxt_c;

    assign nxt_c = {q[W-2:0], ^(q & TAPS)} ^ xin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= nxt_c;
        end
    end

endmodule

// File: rtl/pattern_bist_sequencer.sv
// BIST sequencer: LFSR stimulus held for SETTLE cycles per pattern, MISR compaction of
// the pattern block's response, pattern counting and host start/abort/seed control.
module pattern_bist_sequencer
    import pattern_bist_pkg::*;
#(
    parameter int unsigned    IN_W    = 11,
    parameter int unsigned    OUT_W   = 10,
    parameter int unsigned    NUM_PAT = 256,
    parameter int unsigned    SETTLE  = 2,
    parameter logic [IN_W-1:0] SEED   = IN_W'(DEFAULT_SEED)
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic              abort,
    input  logic              seed_load,
    input  logic [IN_W-1:0]   seed_val,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  signature,
    output logic [PCNT_W-1:0] pat_count
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    state_e            state_q;
    state_e            state_d;
    logic [IN_W-1:0]   seed_q;
    logic [IN_W-1:0]   lfsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              seed_wr_c;
    logic              init_c;
    logic              capture_c;
    logic              advance_c;
    logic              last_c;

    assign last_c = (pat_count + PCNT_W'(1)) == PCNT_W'(NUM_PAT);

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort beats every other request in busy states and in DONE
    always_comb begin
        state_d   = state_q;
        seed_wr_c = 1'b0;
        init_c    = 1'b0;
        capture_c = 1'b0;
        advance_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    seed_wr_c = 1'b1;
                end else if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    init_c  = 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    capture_c = 1'b1;
                    state_d   = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    advance_c = 1'b1;
                    state_d   = last_c ? ST_DONE : ST_APPLY;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The LFSR steps one cycle early (on capture) so ADVANCE can register it straight
    // into dut_in; INIT reloads it, so the early step never leaks across runs.
    bist_shift_reg #(
        .W       (IN_W),
        .TAPS    (IN_W'(LFSR_TAPS)),
        .RST_VAL (SEED)
    ) u_lfsr (
        .clk      (blif_clk_net),
        .rst_n    (blif_reset_net),
        .load     (init_c),
        .load_val (seed_q),
        .en       (capture_c),
        .xin      ('0),
        .q        (lfsr_q)
    );

    bist_shift_reg #(
        .W       (OUT_W),
        .TAPS    (OUT_W'(MISR_TAPS)),
        .RST_VAL ('0)
    ) u_misr (
        .clk      (blif_clk_net),
        .rst_n    (blif_reset_net),
        .load     (init_c),
        .load_val ('0),
        .en       (capture_c),
        .xin      (dut_out),
        .q        (signature)
    );

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            seed_q    <= SEED;
            dut_in    <= '0;
            pat_count <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (seed_wr_c) begin
                seed_q <= (seed_val == '0) ? IN_W'(1) : seed_val;
            end
            if (state_q == ST_APPLY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (init_c) begin
                dut_in    <= seed_q;
                pat_count <= '0;
                cnt_q     <= '0;
            end
            if (advance_c) begin
                dut_in    <= lfsr_q;
                pat_count <= pat_count + PCNT_W'(1);
                cnt_q     <= '0;
            end
            busy <= (state_d == ST_INIT) || (state_d == ST_APPLY) ||
                    (state_d == ST_CAPTURE) || (state_d == ST_ADVANCE);
            done <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_pattern_bist_sequencer.sv
// Self-checking bench for pattern_bist_sequencer: directed vector table, hand-written
// corner sequences and randomized runs against a timeline-based reference model.
module tb_pattern_bist_sequencer;

    localparam int unsigned IN_W  = 11;
    localparam int unsigned OUT_W = 10;
    localparam int          NP    = 4;
    localparam int          S     = 2;
    localparam int          PER   = S + 2;
    localparam int          LAST  = 19;

    typedef struct {
        logic [IN_W-1:0]  dut_in;
        logic             busy;
        logic             done;
        logic [15:0]      pat;
        logic [OUT_W-1:0] sig;
    } exp_t;

    typedef struct {
        logic [OUT_W-1:0] resp;
        int               n;
        logic [IN_W-1:0]  dut_in;
        logic             busy;
        logic             done;
        logic [15:0]      pat;
        logic [OUT_W-1:0] sig;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             seed_load;
    logic [IN_W-1:0]  seed_val;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] signature;
    logic [15:0]      pat_count;

    int checks   = 0;
    int failures = 0;

    logic [OUT_W-1:0] drv [0:63];
    exp_t             obs [0:63];

    always #5 clk = ~clk;

    pattern_bist_sequencer #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .NUM_PAT (NP),
        .SETTLE  (S),
        .SEED    (11'h001)
    ) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .start          (start),
        .abort          (abort),
        .seed_load      (seed_load),
        .seed_val       (seed_val),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .signature      (signature),
        .pat_count      (pat_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] x);
        return {x[IN_W-2:0], x[10] ^ x[8]};
    endfunction

    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] m,
                                                   input logic [OUT_W-1:0] d);
        logic [OUT_W-1:0] r;
        r[0] = m[9] ^ m[6] ^ d[0];
        for (int i = 1; i < OUT_W; i++) r[i] = m[i-1] ^ d[i];
        return r;
    endfunction

    // Expected outputs n edges after the edge that sampled start (n >= 1): pattern k
    // occupies edges 1+k*PER .. (k+1)*PER, its response is captured at edge 2+k*PER+S.
    function automatic exp_t model(input logic [IN_W-1:0] seed, input int n);
        exp_t             e;
        int               p;
        int               steps;
        logic [IN_W-1:0]  x;
        logic [OUT_W-1:0] m;
        p      = (n - 1) / PER;
        e.done = (p >= NP);
        e.busy = !e.done;
        steps  = e.done ? NP : p;
        e.pat  = 16'(steps);
        x = seed;
        for (int k = 0; k < steps; k++) x = lfsr_step(x);
        e.dut_in = x;
        m = '0;
        for (int k = 0; k < NP; k++) begin
            if (2 + k * PER + S <= n) m = misr_step(m, drv[2 + k * PER + S]);
        end
        e.sig = m;
        return e;
    endfunction

    task automatic sample(input int n);
        obs[n].dut_in = dut_in;
        obs[n].busy   = busy;
        obs[n].done   = done;
        obs[n].pat    = pat_count;
        obs[n].sig    = signature;
    endtask

    // Launch a run from IDLE/DONE and compare every cycle up to edge last_n with the model.
    task automatic run_model(input logic [IN_W-1:0] seed, input bit rnd,
                             input logic [OUT_W-1:0] cval, input int last_n);
        exp_t e;
        start  = 1'b1;
        drv[0] = rnd ? OUT_W'($urandom) : cval;
        dut_out = drv[0];
        tick();
        start = 1'b0;
        sample(0);
        chk("init_busy", 32'(busy), 32'(1));
        chk("init_done", 32'(done), 32'(0));
        for (int n = 1; n <= last_n; n++) begin
            drv[n]  = rnd ? OUT_W'($urandom) : cval;
            dut_out = drv[n];
            tick();
            sample(n);
            e = model(seed, n);
            chk($sformatf("run n=%0d dut_in", n), 32'(dut_in), 32'(e.dut_in));
            chk($sformatf("run n=%0d busy", n), 32'(busy), 32'(e.busy));
            chk($sformatf("run n=%0d done", n), 32'(done), 32'(e.done));
            chk($sformatf("run n=%0d pat_count", n), 32'(pat_count), 32'(e.pat));
            chk($sformatf("run n=%0d signature", n), 32'(signature), 32'(e.sig));
        end
    endtask

    task automatic go_idle();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
    endtask

    vec_t             tbl [0:12];
    logic [OUT_W-1:0] clean_sig;
    logic [IN_W-1:0]  rs;
    exp_t             e9;

    initial begin
        tbl[0]  = '{10'h000,  0, 11'h000, 1'b1, 1'b0, 16'd0, 10'h000};
        tbl[1]  = '{10'h000,  1, 11'h001, 1'b1, 1'b0, 16'd0, 10'h000};
        tbl[2]  = '{10'h000,  5, 11'h002, 1'b1, 1'b0, 16'd1, 10'h000};
        tbl[3]  = '{10'h000,  9, 11'h004, 1'b1, 1'b0, 16'd2, 10'h000};
        tbl[4]  = '{10'h000, 16, 11'h008, 1'b1, 1'b0, 16'd3, 10'h000};
        tbl[5]  = '{10'h000, 17, 11'h010, 1'b0, 1'b1, 16'd4, 10'h000};
        tbl[6]  = '{10'h000, 19, 11'h010, 1'b0, 1'b1, 16'd4, 10'h000};
        tbl[7]  = '{10'h001,  0, 11'h010, 1'b1, 1'b0, 16'd4, 10'h000};
        tbl[8]  = '{10'h001,  1, 11'h001, 1'b1, 1'b0, 16'd0, 10'h000};
        tbl[9]  = '{10'h001,  4, 11'h001, 1'b1, 1'b0, 16'd0, 10'h001};
        tbl[10] = '{10'h001,  8, 11'h002, 1'b1, 1'b0, 16'd1, 10'h003};
        tbl[11] = '{10'h001, 17, 11'h010, 1'b0, 1'b1, 16'd4, 10'h00F};
        tbl[12] = '{10'h001, 19, 11'h010, 1'b0, 1'b1, 16'd4, 10'h00F};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        seed_load = 1'b0;
        seed_val  = '0;
        dut_out   = '0;
        repeat (2) tick();
        chk("reset dut_in", 32'(dut_in), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset pat_count", 32'(pat_count), 32'(0));
        chk("reset signature", 32'(signature), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // directed table: two back-to-back runs from the default seed
        for (int i = 0; i < 13; i++) begin
            if (i == 0 || tbl[i].resp != tbl[i-1].resp) run_model(11'h001, 1'b0, tbl[i].resp, LAST);
            chk($sformatf("tbl%0d dut_in", i), 32'(obs[tbl[i].n].dut_in), 32'(tbl[i].dut_in));
            chk($sformatf("tbl%0d busy", i), 32'(obs[tbl[i].n].busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d done", i), 32'(obs[tbl[i].n].done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d pat_count", i), 32'(obs[tbl[i].n].pat), 32'(tbl[i].pat));
            chk($sformatf("tbl%0d signature", i), 32'(obs[tbl[i].n].sig), 32'(tbl[i].sig));
        end

        // abort in DONE, then seed_load together with start: stays IDLE, seed updated
        go_idle();
        seed_val  = 11'h155;
        seed_load = 1'b1;
        start     = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        chk("seed_and_start busy", 32'(busy), 32'(0));
        tick();
        chk("seed_and_start idle", 32'(busy), 32'(0));
        run_model(11'h155, 1'b1, '0, LAST);
        chk("loaded seed first vector", 32'(obs[1].dut_in), 32'(11'h155));

        // zero seed is forced to 1
        go_idle();
        seed_val  = '0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        run_model(11'h001, 1'b1, '0, LAST);
        chk("zero seed first vector", 32'(obs[1].dut_in), 32'(11'h001));

        // abort during APPLY of pattern 3
        go_idle();
        run_model(11'h001, 1'b1, '0, 9);
        e9    = model(11'h001, 9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("apply_abort busy", 32'(busy), 32'(0));
        chk("apply_abort done", 32'(done), 32'(0));
        chk("apply_abort pat_count", 32'(pat_count), 32'(2));
        chk("apply_abort signature", 32'(signature), 32'(e9.sig));
        tick();
        chk("apply_abort stays idle", 32'(busy), 32'(0));

        // asynchronous reset in the middle of CAPTURE
        run_model(11'h001, 1'b0, 10'h2A5, S + 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset dut_in", 32'(dut_in), 32'(0));
        chk("midrun_reset busy", 32'(busy), 32'(0));
        chk("midrun_reset done", 32'(done), 32'(0));
        chk("midrun_reset pat_count", 32'(pat_count), 32'(0));
        chk("midrun_reset signature", 32'(signature), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        clean_sig = '0;
        for (int k = 0; k < NP; k++) clean_sig = misr_step(clean_sig, 10'h2A5);
        run_model(11'h001, 1'b0, 10'h2A5, LAST);
        chk("rerun_after_reset signature", 32'(signature), 32'(clean_sig));

        // randomized seeds and responses
        for (int r = 0; r < 6; r++) begin
            go_idle();
            rs        = (r == 2) ? '0 : IN_W'($urandom);
            seed_val  = rs;
            seed_load = 1'b1;
            tick();
            seed_load = 1'b0;
            run_model((rs == '0) ? 11'h001 : rs, 1'b1, '0, LAST);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_bist_sequencer.md
Name: pattern_bist_sequencer

Overview:
Built-in self-test sequencer for the merged pattern netlists (e.g. the 11-input / 10-output merged pattern blocks).
- Generates pseudo-random input vectors with an LFSR and holds each vector for a programmable settle time.
- Compacts the block's outputs into a MISR signature and counts applied patterns.
- Sits beside the pattern block on the same clock/reset. A test host starts it and reads back the signature.

Parameters:
IN_W, 11, width of stimulus vector driven to the pattern block
OUT_W, 10, width of response vector captured from the pattern block
NUM_PAT, 256, patterns applied per run (1..65535)
SETTLE, 2, cycles each vector is held before capture (>=1)
SEED, 11'h001, LFSR reset/default seed (nonzero)

Ports:
blif_clk_net  input  1  single clock, rising edge
blif_reset_net  input  1  asynchronous, active-low reset
start  input  1  level; sampled in IDLE/DONE to launch a run
abort  input  1  synchronous abort of a running test
seed_load  input  1  in IDLE, load seed_val into seed register
seed_val  input  IN_W  user seed
dut_in  output  IN_W  stimulus to pattern block (registered)
dut_out  input  OUT_W  response from pattern block
busy  output  1  high in INIT/APPLY/CAPTURE/ADVANCE
done  output  1  high while in DONE
signature  output  OUT_W  current MISR value
pat_count  output  16  patterns completed in current/last run

Behaviour:
- Reset (async, blif_reset_net=0) values: state=IDLE, seed reg=SEED, lfsr=SEED, dut_in=0, misr=0, pat_count=0, settle counter=0, busy=0, done=0.
- FSM states: IDLE, INIT, APPLY, CAPTURE, ADVANCE, DONE; all outputs registered.
- IDLE: seed_load=1 loads seed_val; a zero value is forced to 1 (LFSR lock-up guard). If start=1 and seed_load=0, go to INIT. seed_load has priority over start in the same cycle.
- INIT (1 cycle): lfsr<=seed reg, misr<=0, pat_count<=0, settle counter<=0, dut_in<=seed reg; go to APPLY.
- APPLY: dut_in holds lfsr; the counter increments each cycle. After SETTLE cycles in APPLY, go to CAPTURE.
- CAPTURE (1 cycle): misr_next[0]=misr[9]^misr[6]^dut_out[0]; misr_next[i]=misr[i-1]^dut_out[i] for i=1..OUT_W-1 (polynomial x^10+x^7+1). Go to ADVANCE.
- ADVANCE (1 cycle): lfsr<={lfsr[IN_W-2:0], lfsr[10]^lfsr[8]} (x^11+x^9+1), dut_in<=new lfsr, pat_count+1, counter<=0. If pat_count+1==NUM_PAT go to DONE, else go to APPLY.
- DONE: signature and pat_count frozen; done=1. start=1 goes to INIT (rerun, same seed); start=0 stays in DONE. Direct return to IDLE only via abort or reset.
- Timing: start sampled in cycle t gives INIT at t+1 and the first vector at t+2. Each pattern costs SETTLE+2 cycles. done rises at t+2+NUM_PAT*(SETTLE+2).
- abort=1 in any busy state: next state IDLE; misr and pat_count retain partial values; done stays 0. abort in DONE returns to IDLE and clears done. abort wins over start.
- Reset mid-run: immediate asynchronous return to reset values; no partial signature is preserved.
- LFSR period 2047; with NUM_PAT > 2047 vectors repeat. This is legal, no flag.

Decomposition:
- Package pattern_bist_pkg: state enum, default polynomial tap constants (LFSR_TAPS 11-bit, MISR_TAPS 10-bit), SEED default.
- One natural sub-module: bist_shift_reg, a parameterised shift register with an enable and an optional parallel XOR input. It is instantiated twice: as the LFSR (XOR input tied 0) and as the MISR (XOR input = dut_out).

Test Plan:
- Reset, then NUM_PAT=4, SETTLE=2, start pulsed at cycle 0 -> dut_in=11'h001 at cycle 2 and 11'h002 at cycle 6; done=1 at cycle 18; pat_count=4.
- dut_out tied 10'h000 for a full run -> signature=10'h000.
- NUM_PAT=1, dut_out=10'h001 -> signature=10'h001. NUM_PAT=2, dut_out=10'h001 -> signature=10'h003.
- seed_load with seed_val=0 in IDLE, then start -> first dut_in=11'h001. seed_load and start in the same cycle -> stays IDLE, seed updated.
- abort asserted during APPLY of pattern 3 -> IDLE next cycle; done=0, busy=0, pat_count=2.
- blif_reset_net driven low mid-CAPTURE (asynchronously) -> all outputs return to reset values before the next clock edge. Rerun after release matches a clean-run signature.
